// File: rtl/cmp_pkg.sv
// Shared types for the comparator-sharing arbiter: FSM states, counter width
// and the registered comparison result.
package cmp_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        CMP,
        RSP
    } state_t;

    typedef struct packed {
        logic lesser;
        logic greater;
        logic equal;
    } cmp_res_t;

endpackage

// File: rtl/cmp_core.sv
// Purely combinational unsigned magnitude comparator producing the
// lesser/greater/equal flag triple.
module cmp_core
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output cmp_res_t         res
);

    always_comb begin
        res         = '0;
        res.lesser  = (a < b);
        res.greater = (a > b);
        res.equal   = (a == b);
    end

endmodule

// File: rtl/cmp_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one magnitude comparator among NREQ
// requesters, with a registered valid/ready result and a completion counter.
module cmp_share_arbiter
    import cmp_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned NREQ  = 4,
    localparam int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] a_in,
    input  logic [NREQ*WIDTH-1:0] b_in,
    output logic [NREQ-1:0]       gnt,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic                  lesser,
    output logic                  greater,
    output logic                  equal,
    output logic                  busy,
    output logic [CNT_W-1:0]      done_cnt
);

    localparam logic [IDW:0] NREQ_W = (IDW+1)'(NREQ);

    state_t            state;
    state_t            state_nxt;
    logic [IDW-1:0]    ptr;
    logic [IDW-1:0]    cur_id;
    logic [IDW-1:0]    sel;
    logic [IDW-1:0]    off;
    logic [IDW:0]      sum;
    logic [2*NREQ-1:0] dbl;
    logic              found;
    logic              take;
    logic              finish;
    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]  a_sel;
    logic [WIDTH-1:0]  b_sel;
    logic [CNT_W-1:0]  cnt_nxt;
    cmp_res_t          res_c;
    cmp_res_t          res_q;

    // Rotate req so ptr sits at bit 0, take the lowest set bit, then add ptr
    // back modulo NREQ to recover the absolute requester index.
    always_comb begin
        dbl   = {req, req} >> ptr;
        off   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!found && dbl[i]) begin
                found = 1'b1;
                off   = IDW'(i);
            end
        end
        sum = {1'b0, ptr} + {1'b0, off};
        sel = (sum >= NREQ_W) ? IDW'(sum - NREQ_W) : sum[IDW-1:0];
    end

    always_comb begin
        a_sel = '0;
        b_sel = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (sel == IDW'(i)) begin
                a_sel = a_in[i*WIDTH +: WIDTH];
                b_sel = b_in[i*WIDTH +: WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        finish    = 1'b0;
        case (state)
            IDLE: begin
                if (|req) begin
                    take      = 1'b1;
                    state_nxt = CMP;
                end
            end
            CMP: begin
                state_nxt = RSP;
            end
            RSP: begin
                if (rsp_ready) begin
                    finish    = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    cmp_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .a  (op_a),
        .b  (op_b),
        .res(res_c)
    );

    assign cnt_nxt = done_cnt + CNT_W'(finish);

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            cur_id   <= '0;
            gnt      <= '0;
            res_q    <= '0;
            ptr      <= '0;
            done_cnt <= '0;
        end else begin
            gnt <= '0;
            if (take) begin
                op_a   <= a_sel;
                op_b   <= b_sel;
                cur_id <= sel;
                gnt    <= NREQ'(1) << sel;
            end
            if (state == CMP) begin
                res_q <= res_c;
            end
            if (finish) begin
                ptr <= (cur_id == IDW'(NREQ - 1)) ? '0 : cur_id + IDW'(1);
            end
            done_cnt <= cnt_nxt;
        end
    end

    assign rsp_valid = (state == RSP);
    assign busy      = (state != IDLE);
    assign rsp_id    = cur_id;
    assign lesser    = res_q.lesser;
    assign greater   = res_q.greater;
    assign equal     = res_q.equal;

endmodule

// File: tb/tb_cmp_share_arbiter.sv
// Self-checking bench for cmp_share_arbiter: directed vector table, abort and
// counter-wrap sequences, then randomized traffic against a behavioural model.
module tb_cmp_share_arbiter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned NREQ  = 4;
    localparam int unsigned IDW   = 2;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] a_in;
    logic [NREQ*WIDTH-1:0] b_in;
    logic [NREQ-1:0]       gnt;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic                  lesser;
    logic                  greater;
    logic                  equal;
    logic                  busy;
    logic [15:0]           done_cnt;

    int          n_cmp = 0;
    int          n_bad = 0;
    int unsigned m_ptr;
    logic [15:0] m_cnt;

    typedef struct {
        bit                    rst_first;
        logic [NREQ-1:0]       rv;
        logic [NREQ*WIDTH-1:0] av;
        logic [NREQ*WIDTH-1:0] bv;
        int unsigned           stall;
        int unsigned           exp_id;
        logic [2:0]            exp_f;
    } vec_t;

    vec_t tbl[$];

    localparam logic [2:0] F_L = 3'b100;
    localparam logic [2:0] F_G = 3'b010;
    localparam logic [2:0] F_E = 3'b001;

    cmp_share_arbiter #(
        .WIDTH(WIDTH),
        .NREQ (NREQ)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .a_in     (a_in),
        .b_in     (b_in),
        .gnt      (gnt),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_id   (rsp_id),
        .lesser   (lesser),
        .greater  (greater),
        .equal    (equal),
        .busy     (busy),
        .done_cnt (done_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required finish first");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // First requester at or after p (cyclically) with its req bit set.
    function automatic int unsigned pick(input logic [NREQ-1:0] r, input int unsigned p);
        for (int unsigned k = 0; k < NREQ; k++) begin
            if (r[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return 0;
    endfunction

    function automatic logic [2:0] flags_of(input int unsigned a, input int unsigned b);
        if (a < b) return F_L;
        if (a > b) return F_G;
        return F_E;
    endfunction

    task automatic do_reset();
        rst       = 1'b1;
        req       = '0;
        rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst   = 1'b0;
        m_ptr = 0;
        m_cnt = '0;
    endtask

    // Starts at a negedge with the DUT idle; ends at the negedge after completion.
    task automatic do_txn(input logic [NREQ-1:0] rv, input logic [NREQ*WIDTH-1:0] av,
                          input logic [NREQ*WIDTH-1:0] bv, input int unsigned stall,
                          input int unsigned exp_id, input logic [2:0] exp_f, input string tag);
        logic [15:0] nc;
        req       = rv;
        a_in      = av;
        b_in      = bv;
        rsp_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check({tag, "_gnt"}, 32'(gnt), 32'(1) << exp_id);
        check({tag, "_busy_cmp"}, 32'(busy), 32'd1);
        check({tag, "_valid_cmp"}, 32'(rsp_valid), 32'd0);
        a_in      = $urandom;
        b_in      = $urandom;
        rsp_ready = 1'($urandom_range(0, 1));
        @(negedge clk);
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_id"}, 32'(rsp_id), 32'(exp_id));
        check({tag, "_flags"}, 32'({lesser, greater, equal}), 32'(exp_f));
        check({tag, "_gnt_rsp"}, 32'(gnt), 32'd0);
        for (int unsigned j = 0; j < stall; j++) begin
            rsp_ready = 1'b0;
            req       = '1;
            @(negedge clk);
            check({tag, "_hold_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, "_hold_id"}, 32'(rsp_id), 32'(exp_id));
            check({tag, "_hold_flags"}, 32'({lesser, greater, equal}), 32'(exp_f));
            check({tag, "_hold_gnt"}, 32'(gnt), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        nc = m_cnt + 16'd1;
        check({tag, "_done_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_done_busy"}, 32'(busy), 32'd0);
        check({tag, "_done_cnt"}, 32'(done_cnt), 32'(nc));
        m_cnt     = nc;
        m_ptr     = (exp_id + 1) % NREQ;
        req       = '0;
        rsp_ready = 1'b0;
    endtask

    task automatic do_txn_m(input logic [NREQ-1:0] rv, input logic [NREQ*WIDTH-1:0] av,
                            input logic [NREQ*WIDTH-1:0] bv, input int unsigned stall,
                            input string tag);
        int unsigned w;
        logic [WIDTH-1:0] wa;
        logic [WIDTH-1:0] wb;
        w  = pick(rv, m_ptr);
        wa = av[w*WIDTH +: WIDTH];
        wb = bv[w*WIDTH +: WIDTH];
        do_txn(rv, av, bv, stall, w, flags_of(wa, wb), tag);
    endtask

    // n=1 asserts rst while in CMP, n=2 while in RSP.
    task automatic abort_txn(input logic [NREQ-1:0] rv, input logic [NREQ*WIDTH-1:0] av,
                             input logic [NREQ*WIDTH-1:0] bv, input int unsigned n,
                             input logic [2:0] exp_f, input string tag);
        req       = rv;
        a_in      = av;
        b_in      = bv;
        rsp_ready = 1'b0;
        repeat (n) @(negedge clk);
        if (n == 2) begin
            check({tag, "_pre_valid"}, 32'(rsp_valid), 32'd1);
            check({tag, "_pre_flags"}, 32'({lesser, greater, equal}), 32'(exp_f));
        end
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        check({tag, "_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_flags"}, 32'({lesser, greater, equal}), 32'd0);
        check({tag, "_cnt"}, 32'(done_cnt), 32'd0);
        check({tag, "_gnt"}, 32'(gnt), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_id"}, 32'(rsp_id), 32'd0);
        rst   = 1'b0;
        m_ptr = 0;
        m_cnt = '0;
    endtask

    initial begin
        logic [NREQ-1:0]       rv;
        logic [NREQ*WIDTH-1:0] av;
        logic [NREQ*WIDTH-1:0] bv;

        rst       = 1'b1;
        req       = '0;
        a_in      = '0;
        b_in      = '0;
        rsp_ready = 1'b0;
        m_ptr     = 0;
        m_cnt     = '0;
        repeat (2) @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_id", 32'(rsp_id), 32'd0);
        check("rst_flags", 32'({lesser, greater, equal}), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cnt", 32'(done_cnt), 32'd0);
        rst = 1'b0;

        // Lanes packed {r3, r2, r1, r0}.
        tbl.push_back('{1'b0, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd111}, {8'd0, 8'd0, 8'd0, 8'd250}, 0, 0, F_L});
        tbl.push_back('{1'b1, 4'b1111, {8'd85, 8'd255, 8'd199, 8'd147}, {8'd25, 8'd255, 8'd220, 8'd103}, 0, 0, F_G});
        tbl.push_back('{1'b0, 4'b1111, {8'd85, 8'd255, 8'd199, 8'd147}, {8'd25, 8'd255, 8'd220, 8'd103}, 0, 1, F_L});
        tbl.push_back('{1'b0, 4'b1111, {8'd85, 8'd255, 8'd199, 8'd147}, {8'd25, 8'd255, 8'd220, 8'd103}, 0, 2, F_E});
        tbl.push_back('{1'b0, 4'b1111, {8'd85, 8'd255, 8'd199, 8'd147}, {8'd25, 8'd255, 8'd220, 8'd103}, 0, 3, F_G});
        tbl.push_back('{1'b0, 4'b1111, {8'd85, 8'd255, 8'd199, 8'd147}, {8'd25, 8'd255, 8'd220, 8'd103}, 0, 0, F_G});
        tbl.push_back('{1'b0, 4'b0010, {8'd0, 8'd0, 8'd96, 8'd0}, {8'd0, 8'd0, 8'd96, 8'd0}, 5, 1, F_E});
        tbl.push_back('{1'b1, 4'b1001, {8'd200, 8'd0, 8'd0, 8'd5}, {8'd100, 8'd0, 8'd0, 8'd9}, 0, 0, F_L});
        tbl.push_back('{1'b0, 4'b1001, {8'd200, 8'd0, 8'd0, 8'd5}, {8'd100, 8'd0, 8'd0, 8'd9}, 0, 3, F_G});
        tbl.push_back('{1'b0, 4'b1001, {8'd200, 8'd0, 8'd0, 8'd5}, {8'd100, 8'd0, 8'd0, 8'd9}, 1, 0, F_L});
        tbl.push_back('{1'b0, 4'b1001, {8'd200, 8'd0, 8'd0, 8'd5}, {8'd100, 8'd0, 8'd0, 8'd9}, 0, 3, F_G});
        tbl.push_back('{1'b0, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd0}, {8'd0, 8'd0, 8'd0, 8'd255}, 0, 0, F_L});
        tbl.push_back('{1'b0, 4'b0001, {8'd0, 8'd0, 8'd0, 8'd255}, {8'd0, 8'd0, 8'd0, 8'd0}, 2, 0, F_G});

        foreach (tbl[i]) begin
            if (tbl[i].rst_first) do_reset();
            do_txn(tbl[i].rv, tbl[i].av, tbl[i].bv, tbl[i].stall, tbl[i].exp_id, tbl[i].exp_f,
                   $sformatf("v%0d", i));
        end

        // Reset in RSP discards the result; requester 2 is then granted.
        do_reset();
        do_txn_m(4'b0010, {8'd0, 8'd0, 8'd3, 8'd0}, {8'd0, 8'd0, 8'd4, 8'd0}, 0, "ab_pre");
        abort_txn(4'b0100, {8'd0, 8'd79, 8'd0, 8'd0}, {8'd0, 8'd74, 8'd0, 8'd0}, 2, F_G, "ab_rsp");
        do_txn_m(4'b0100, {8'd0, 8'd79, 8'd0, 8'd0}, {8'd0, 8'd74, 8'd0, 8'd0}, 0, "ab_post");

        // Reset in CMP must also clear ptr: with ptr left at 2 the next pick would be 2, not 0.
        do_txn_m(4'b0010, {8'd0, 8'd0, 8'd9, 8'd0}, {8'd0, 8'd0, 8'd9, 8'd0}, 0, "pr_pre");
        abort_txn(4'b0100, {8'd0, 8'd1, 8'd0, 8'd0}, {8'd0, 8'd2, 8'd0, 8'd0}, 1, F_L, "pr_cmp");
        do_txn_m(4'b0101, {8'd0, 8'd6, 8'd0, 8'd7}, {8'd0, 8'd6, 8'd0, 8'd7}, 0, "pr_post");

        for (int t = 0; t < 150; t++) begin
            if ($urandom_range(0, 5) == 0) begin
                req       = '0;
                rsp_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                check("idle_gnt", 32'(gnt), 32'd0);
                check("idle_busy", 32'(busy), 32'd0);
                check("idle_cnt", 32'(done_cnt), 32'(m_cnt));
            end
            rv = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            av = $urandom;
            bv = $urandom;
            for (int unsigned k = 0; k < NREQ; k++) begin
                case ($urandom_range(0, 5))
                    0: bv[k*WIDTH +: WIDTH] = av[k*WIDTH +: WIDTH];
                    1: begin av[k*WIDTH +: WIDTH] = '0; bv[k*WIDTH +: WIDTH] = '1; end
                    2: begin av[k*WIDTH +: WIDTH] = '1; end
                    default: ;
                endcase
            end
            do_txn_m(rv, av, bv, $urandom_range(0, 3), $sformatf("r%0d", t));
        end

        // Preload the counter to its maximum; one more completion wraps to 0.
        req = '0;
        force dut.done_cnt = 16'hFFFF;
        @(negedge clk);
        release dut.done_cnt;
        m_cnt = 16'hFFFF;
        do_txn_m(4'b0100, {8'd0, 8'd12, 8'd0, 8'd0}, {8'd0, 8'd13, 8'd0, 8'd0}, 0, "wrap");
        do_txn_m(4'b1000, {8'd14, 8'd0, 8'd0, 8'd0}, {8'd14, 8'd0, 8'd0, 8'd0}, 0, "wrap1");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
